alu_instr_issuer: RTL
=====================

Name: alu_instr_issuer

Overview:
Upstream feeder for the 4-stage ALU pipeline. It writes instruction words from a host into an internal FIFO and issues them to the pipeline one per cycle under valid/ready. It tracks each issued instruction through the fixed pipeline latency and tags the returning result with its opcode and sequence number. This replaces the pipeline's preloaded instruction ROM with a streamed source.

Parameters:
WIDTH, 8, operand and result width; instruction word is 2+2*WIDTH bits ({op[1:0], src1, src2}).
DEPTH, 4, FIFO entries; power of two, 2..16.
LATENCY, 3, cycles from issue handshake edge to the cycle in which result_in carries that instruction's result.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  host instruction valid
in_ready  out  1  FIFO can accept
in_instr  in  2*WIDTH+2  host instruction word
flush  in  1  single-cycle pulse; discards queued (unissued) instructions
issue_valid  out  1  head instruction presented to pipeline
issue_ready  in  1  pipeline accepts
issue_instr  out  2*WIDTH+2  FIFO head word
result_in  in  WIDTH  pipeline writeback result
out_valid  out  1  tagged result valid (1-cycle pulse per instruction)
out_result  out  WIDTH  captured result
out_op  out  2  opcode of that instruction
out_seq  out  8  sequence number of that instruction
fifo_count  out  clog2(DEPTH)+1  queued entries
busy  out  1  state != IDLE
done  out  1  1-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset (reset=0, async): FIFO empty, pointers/count 0, seq counter 0, tracking pipe cleared, state IDLE. All outputs 0 except in_ready=1. Reset mid-operation drops queued and in-flight instructions; no out_valid for them.
- Push: on rising edge with in_valid && in_ready. in_ready = (fifo_count < DEPTH), independent of same-cycle pop (no full-pop bypass).
- Issue: issue_valid = (fifo_count != 0) && !flush; issue_instr = head word (combinational from FIFO). Pop on edge with issue_valid && issue_ready. No empty bypass: a word pushed in cycle t is issuable no earlier than t+1.
- Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
- Flush: on edge with flush=1, FIFO emptied (count 0, rd_ptr=wr_ptr); a same-cycle push is dropped; no pop that cycle. In-flight instructions still complete and report.
- Sequence: 8-bit counter, increments on each issue handshake, wraps 255->0; issued instruction tagged with the pre-increment value.
- Tracking: LATENCY-deep shift of {valid, op, seq}, advancing every cycle; stage 0 loaded with the issue handshake. When the last stage is valid, result_in is sampled; out_valid=1 on the following cycle with out_result/out_op/out_seq. So out_valid rises LATENCY+1 cycles after the issue edge. out_result/out_op/out_seq hold their last value when out_valid=0.
- FSM:
  - IDLE -> ISSUE when fifo_count != 0.
  - ISSUE -> DRAIN when the FIFO becomes empty (last pop or flush) and in-flight != 0.
  - ISSUE -> IDLE directly if empty with nothing in flight (flush before any issue); done pulses.
  - DRAIN -> ISSUE when a new word arrives.
  - DRAIN -> IDLE when the tracking pipe empties; done=1 for one cycle.
- Widths: all data passed through unmodified; no arithmetic beyond pointer/count/seq.

Test Plan:
1. Reset, then push {00,10,5},{01,20,8},{10,15,3},{11,12,4} back-to-back with issue_ready=1; bench model returns 15,12,3,12 → out_valid four consecutive cycles, out_seq 0..3, out_op 0..3, results 15,12,3,12; done pulses once after the last.
2. issue_ready=0, push 5 words → in_ready=0 after 4, fifo_count=4, 5th held; raise issue_ready → all 5 issued in order, seq 0..4.
3. FIFO at count 2, in_valid and issue handshake same cycle → count stays 2; pointers wrap correctly over 20 mixed operations, results in order.
4. Issue 2, queue 3 more, pulse flush → exactly 2 out_valid pulses (seq 0,1), fifo_count=0, next pushed word tagged seq 2.
5. Issue 300 instructions → out_seq wraps 255→0, no dropped or duplicated out_valid.
6. Drive reset low with 2 queued and 2 in flight → all outputs 0, in_ready=1 immediately; no out_valid after release; next issue tagged seq 0.

Source files
------------

// File: rtl/alu_instr_issuer_if.sv
// Host-side and pipeline-side signals of the ALU instruction issuer.
// The slave modport is the issuer; the master modport is whoever drives the host, pipeline and flush inputs.
interface alu_instr_issuer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int IW = 2 * WIDTH + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    in_instr;
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [IW-1:0]    issue_instr;
  logic [WIDTH-1:0] result_in;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_op;
  logic [7:0]       out_seq;
  logic [CW-1:0]    fifo_count;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_instr, flush, issue_ready, result_in,
    input  in_ready, issue_valid, issue_instr, out_valid, out_result,
           out_op, out_seq, fifo_count, busy, done
  );

  modport slave (
    input  in_valid, in_instr, flush, issue_ready, result_in,
    output in_ready, issue_valid, issue_instr, out_valid, out_result,
           out_op, out_seq, fifo_count, busy, done
  );
endinterface

// File: rtl/alu_instr_issuer.sv
// Streams host instruction words through a small FIFO into the 4-stage ALU pipeline and
// tags each returning result with its opcode and issue sequence number.
module alu_instr_issuer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input logic               clk,
  input logic               reset,
  alu_instr_issuer_if.slave bus
);
  localparam int IW = 2 * WIDTH + 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic [7:0] seq;
  } trk_t;

  logic [IW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_seq;
  trk_t             r_trk [LATENCY];
  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [1:0]       r_out_op;
  logic [7:0]       r_out_seq;

  logic             w_not_empty;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_head_op;
  logic [CW-1:0]    w_count_nxt;
  logic             w_inflight_nxt;

  assign w_not_empty     = (r_count != '0);
  assign bus.in_ready    = (r_count < CW'(DEPTH));
  assign bus.issue_valid = w_not_empty && !bus.flush;
  // Gated so the bus reads zero while the FIFO is empty, including straight out of reset.
  assign bus.issue_instr = w_not_empty ? r_mem[r_rd_ptr] : '0;

  assign w_push    = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_pop     = bus.issue_valid && bus.issue_ready;
  assign w_head_op = r_mem[r_rd_ptr][IW-1 -: 2];

  // NOTE: every variable written here gets a default first, otherwise synthesis infers a latch.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Anything still owed a result after this edge: a new issue or a stage that will shift onward.
  always_comb begin
    w_inflight_nxt = w_pop;
    for (int i = 0; i < LATENCY - 1; i++) begin
      w_inflight_nxt = w_inflight_nxt | r_trk[i].valid;
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (bus.flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
          r_seq    <= r_seq + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_trk[i] <= '0;
      end
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_op     <= '0;
      r_out_seq    <= '0;
    end else begin
      r_trk[0] <= '{valid: w_pop, op: w_head_op, seq: r_seq};
      for (int i = 1; i < LATENCY; i++) begin
        r_trk[i] <= r_trk[i-1];
      end
      r_out_valid <= r_trk[LATENCY-1].valid;
      if (r_trk[LATENCY-1].valid) begin
        r_out_result <= bus.result_in;
        r_out_op     <= r_trk[LATENCY-1].op;
        r_out_seq    <= r_trk[LATENCY-1].seq;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_not_empty) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_count_nxt == '0) begin
            if (w_inflight_nxt) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_count_nxt != '0) begin
            r_state <= S_ISSUE;
          end else if (!w_inflight_nxt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_op     = r_out_op;
  assign bus.out_seq    = r_out_seq;
  assign bus.fifo_count = r_count;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule
